// File: rtl/an_rx_pkg.sv
// Shared definitions for the AN_RX measurement path: default widths, clock-derived
// timeout and the scheduler state encoding.
package an_rx_pkg;

   localparam int C_LV_W_DEF    = 12;
   localparam int C_F_CKM       = 48_000_000;
   localparam int C_TIMEOUT_DEF = C_F_CKM / 10;   // 100 ms

   typedef enum logic [2:0] {
      S_IDLE        = 3'd0,
      S_START       = 3'd1,
      S_WAIT_DONE   = 3'd2,
      S_EMIT        = 3'd3,
      S_WAIT_PERIOD = 3'd4
   } state_e;

endpackage

// File: rtl/an_rx_lv_hyst.sv
// Registered hysteresis comparator: updates the level decision on each new average,
// set threshold checked first so crossed thresholds still resolve deterministically.
module an_rx_lv_hyst
   import an_rx_pkg::*;
#(
   parameter int C_LV_W = C_LV_W_DEF
) (
   input  logic              CK_i,
   input  logic              ARST_i,
   input  logic [C_LV_W-1:0] AVG_i,
   input  logic              AVG_VLD_i,
   input  logic [C_LV_W-1:0] THR_HI_i,
   input  logic [C_LV_W-1:0] THR_LO_i,
   output logic              LV_o
);

   logic lv_q, lv_d;

   always_comb begin
      lv_d = lv_q;
      if (AVG_VLD_i) begin
         if (AVG_i >= THR_HI_i)
            lv_d = 1'b1;
         else if (AVG_i < THR_LO_i)
            lv_d = 1'b0;
      end
   end

   always_ff @(posedge CK_i or posedge ARST_i) begin
      if (ARST_i)
         lv_q <= 1'b0;
      else
         lv_q <= lv_d;
   end

   assign LV_o = lv_q;

endmodule

// File: rtl/an_rx_meas_sched.sv
// Measurement scheduler for the level detector: periodic start/done handshake with
// timeout, 2^C_AVG_LOG2-sample averaging and a hysteresis level decision.
module an_rx_meas_sched
   import an_rx_pkg::*;
#(
   parameter int C_LV_W     = C_LV_W_DEF,
   parameter int C_AVG_LOG2 = 2,
   parameter int C_PERIOD_W = 24,
   parameter int C_TIMEOUT  = C_TIMEOUT_DEF
) (
   input  logic                  CK_i,
   input  logic                  ARST_i,
   input  logic                  EN_i,
   input  logic [C_PERIOD_W-1:0] PERIOD_i,
   input  logic [C_LV_W-1:0]     THR_HI_i,
   input  logic [C_LV_W-1:0]     THR_LO_i,
   input  logic                  CLR_ERR_i,
   output logic                  DET_START_o,
   input  logic                  DET_DONE_i,
   input  logic [C_LV_W-1:0]     DET_LVs_i,
   output logic [C_LV_W-1:0]     AVG_LVs_o,
   output logic                  AVG_VLD_o,
   output logic                  LV_o,
   output logic                  TIMEOUT_o
);

   localparam int ACC_W = C_LV_W + C_AVG_LOG2;
   localparam int CNT_W = C_AVG_LOG2 + 1;
   localparam int TMO_W = $clog2(C_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] LAST_SMP = CNT_W'((1 << C_AVG_LOG2) - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(C_TIMEOUT - 1);

   state_e                state_q, state_d;
   logic [ACC_W-1:0]      acc_q, acc_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [C_PERIOD_W-1:0] per_q, per_d, per_load;
   logic [TMO_W-1:0]      tmo_q, tmo_d;
   logic [C_LV_W-1:0]     avg_q, avg_d;
   logic                  start_q, start_d;
   logic                  vld_q, vld_d;
   logic                  to_q, to_d;

   assign per_load = (PERIOD_i == '0) ? C_PERIOD_W'(1) : PERIOD_i;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      per_d   = per_q;
      tmo_d   = '0;
      avg_d   = avg_q;
      vld_d   = 1'b0;
      to_d    = to_q & ~CLR_ERR_i;
      case (state_q)
         S_IDLE: begin
            if (EN_i)
               state_d = S_START;
         end
         S_START: begin
            // the start-pulse cycle is the first cycle of the timeout window
            tmo_d   = TMO_W'(1);
            state_d = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            if (DET_DONE_i) begin
               acc_d = acc_q + ACC_W'(DET_LVs_i);
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST_SMP) begin
                  state_d = S_EMIT;
               end else begin
                  state_d = S_WAIT_PERIOD;
                  per_d   = per_load;
               end
            end else if (tmo_q == TMO_LAST) begin
               to_d    = 1'b1;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = S_WAIT_PERIOD;
               per_d   = per_load;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         S_EMIT: begin
            avg_d   = C_LV_W'(acc_q >> C_AVG_LOG2);
            vld_d   = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_WAIT_PERIOD;
            per_d   = per_load;
         end
         S_WAIT_PERIOD: begin
            if (!EN_i) begin
               state_d = S_IDLE;
               acc_d   = '0;
               cnt_d   = '0;
               per_d   = '0;
            end else if (per_q <= C_PERIOD_W'(1)) begin
               state_d = S_START;
               per_d   = '0;
            end else begin
               per_d = per_q - 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      start_d = (state_d == S_START);
   end

   always_ff @(posedge CK_i or posedge ARST_i) begin
      if (ARST_i) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         per_q   <= '0;
         tmo_q   <= '0;
         avg_q   <= '0;
         start_q <= 1'b0;
         vld_q   <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         per_q   <= per_d;
         tmo_q   <= tmo_d;
         avg_q   <= avg_d;
         start_q <= start_d;
         vld_q   <= vld_d;
         to_q    <= to_d;
      end
   end

   an_rx_lv_hyst #(.C_LV_W(C_LV_W)) u_hyst (
      .CK_i      (CK_i),
      .ARST_i    (ARST_i),
      .AVG_i     (avg_d),
      .AVG_VLD_i (vld_d),
      .THR_HI_i  (THR_HI_i),
      .THR_LO_i  (THR_LO_i),
      .LV_o      (LV_o)
   );

   assign DET_START_o = start_q;
   assign AVG_LVs_o   = avg_q;
   assign AVG_VLD_o   = vld_q;
   assign TIMEOUT_o   = to_q;

endmodule

// File: tb/tb_an_rx_meas_sched.sv
// Self-checking bench: acts as the level detector and predicts starts, averages,
// level decision and timeout flag from a sample-list model.
module tb_an_rx_meas_sched;

   localparam int TMO = 20;

   logic        CK = 1'b0, ARST = 1'b1, EN = 1'b0, CLR = 1'b0, DONE = 1'b0;
   logic [23:0] PERIOD = '0;
   logic [11:0] HI = '0, LO = '0, LVS = '0;
   logic        DSTART, AVG_VLD, LV, TOUT;
   logic [11:0] AVG;

   an_rx_meas_sched #(.C_LV_W(12), .C_AVG_LOG2(2), .C_PERIOD_W(24), .C_TIMEOUT(TMO)) dut (
      .CK_i(CK), .ARST_i(ARST), .EN_i(EN), .PERIOD_i(PERIOD),
      .THR_HI_i(HI), .THR_LO_i(LO), .CLR_ERR_i(CLR),
      .DET_START_o(DSTART), .DET_DONE_i(DONE), .DET_LVs_i(LVS),
      .AVG_LVs_o(AVG), .AVG_VLD_o(AVG_VLD), .LV_o(LV), .TIMEOUT_o(TOUT)
   );

   always #5 CK = ~CK;

   int          cyc = 0, nchk = 0, npass = 0;
   int          nstart_seen = 0, nstart_exp = 0;
   int          exp_next = -1;
   int          smp[$];
   logic [11:0] exp_avg = '0;
   bit          exp_lv = 1'b0, exp_to = 1'b0;

   always @(negedge CK) if (DSTART === 1'b1) nstart_seen++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge CK);
         #1;
         cyc++;
      end
   endtask

   function automatic int eff_period();
      return (PERIOD == 0) ? 1 : int'(PERIOD);
   endfunction

   task automatic wait_start(output int s);
      int n;
      n = 0;
      while (DSTART !== 1'b1 && n < 400) begin
         step();
         n++;
      end
      chk("start_seen", DSTART, 1);
      if (exp_next >= 0) chk("start_cycle", cyc, exp_next);
      nstart_exp++;
      s = cyc;
   endtask

   // One measurement answered d cycles after the start pulse.
   task automatic meas(input int d, input logic [11:0] lv, input bit spur = 1'b0,
                       input bit drop_en = 1'b0);
      int s, dc, sum;
      bit last;
      wait_start(s);
      if (drop_en) begin
         step();
         EN = 1'b0;
         step(d - 1);
      end else begin
         step(d);
      end
      DONE = 1'b1;
      LVS  = lv;
      dc   = cyc;
      smp.push_back(int'(lv));
      last = (smp.size() == 4);
      exp_next = dc + 1 + (last ? 1 : 0) + eff_period();
      step();
      DONE = spur;
      LVS  = spur ? 12'($urandom_range(1, 4095)) : 12'd0;
      chk("vld_early", AVG_VLD, 0);
      step();
      DONE = 1'b0;
      LVS  = '0;
      if (last) begin
         sum = 0;
         foreach (smp[i]) sum += smp[i];
         exp_avg = 12'(sum / 4);
         if (int'(exp_avg) >= int'(HI)) exp_lv = 1'b1;
         else if (int'(exp_avg) < int'(LO)) exp_lv = 1'b0;
         smp.delete();
      end
      chk("avg_vld", AVG_VLD, last);
      chk("avg_val", AVG, exp_avg);
      chk("lv", LV, exp_lv);
      chk("timeout_flag", TOUT, exp_to);
      chk("start_count", nstart_seen, nstart_exp);
   endtask

   // Detector never answers; optional clear request on the timeout cycle itself.
   task automatic meas_silent(input bit clr_same);
      int s;
      wait_start(s);
      step(TMO - 1);
      chk("to_early", TOUT, exp_to);
      CLR = clr_same;
      exp_next = s + TMO + eff_period();
      step();
      CLR = 1'b0;
      exp_to = 1'b1;
      smp.delete();
      chk("to_set", TOUT, 1);
      chk("to_no_vld", AVG_VLD, 0);
   endtask

   task automatic clr_err();
      CLR = 1'b1;
      step();
      CLR = 1'b0;
      exp_to = 1'b0;
      chk("to_clr", TOUT, 0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_start"}, DSTART, 0);
      chk({tag, "_avg"}, AVG, 0);
      chk({tag, "_vld"}, AVG_VLD, 0);
      chk({tag, "_lv"}, LV, 0);
      chk({tag, "_to"}, TOUT, 0);
   endtask

   initial begin
      int s;
      step(2);
      chk_all_zero("rst");

      PERIOD = 24'd10;
      HI = 12'd200;
      LO = 12'd100;
      ARST = 1'b0;
      EN = 1'b1;
      exp_next = cyc + 1;
      meas(5, 12'd100); meas(5, 12'd200); meas(5, 12'd300); meas(5, 12'd400);
      chk("avg_250", AVG, 250);
      chk("four_starts", nstart_seen, 4);

      repeat (4) meas(5, 12'd150);
      repeat (4) meas(5, 12'd50);
      repeat (4) meas(5, 12'd150);
      chk("hyst_hold_low", LV, 0);

      meas(3, 12'd1); meas(3, 12'd1); meas(3, 12'd1); meas(3, 12'd2);
      repeat (4) meas(2, 12'd4095);
      chk("avg_max", AVG, 4095);

      PERIOD = 24'd0;
      repeat (4) meas(4, 12'($urandom_range(0, 4095)));

      PERIOD = 24'd3;
      meas(6, 12'd500); meas(6, 12'd700);
      meas_silent(1'b0);
      clr_err();
      repeat (3) meas(7, 12'($urandom_range(0, 4095)));
      meas(TMO - 1, 12'($urandom_range(0, 4095)));
      meas_silent(1'b1);

      for (int k = 0; k < 24; k++) begin
         PERIOD = 24'($urandom_range(0, 7));
         if (k % 4 == 0) begin
            HI = 12'($urandom_range(0, 4095));
            LO = 12'($urandom_range(0, 4095));
         end
         meas($urandom_range(1, 15), 12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)));
      end

      PERIOD = 24'd2;
      meas(6, 12'($urandom_range(0, 4095)), 1'b0, 1'b1);
      smp.delete();
      step(40);
      chk("no_start_after_en_drop", nstart_seen, nstart_exp);
      EN = 1'b1;
      exp_next = cyc + 1;

      HI = 12'd100;
      LO = 12'd50;
      repeat (4) meas(3, 12'd3000);
      repeat (3) meas(3, 12'($urandom_range(0, 4095)));
      wait_start(s);
      step(2);
      #2 ARST = 1'b1;
      #1;
      chk_all_zero("async_rst");
      step();
      ARST = 1'b0;
      exp_next = cyc + 1;
      smp.delete();
      exp_avg = '0;
      exp_lv = 1'b0;
      exp_to = 1'b0;
      meas(4, 12'd10); meas(4, 12'd20); meas(4, 12'd30); meas(4, 12'd41);
      chk("avg_after_rst", AVG, 25);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
